// File: rtl/shared_event_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_event_fifo_pkg
// Description : Shared larpix constants. These set the default packet width
//               and event FIFO geometry used by the shared event FIFO and
//               its storage array.
// Revision    : 1.0 - initial release
// ============================================================================
package shared_event_fifo_pkg;

  // Packet width; the stored word drops one bit, so it is WIDTH-1 bits wide.
  localparam int c_larpix_width      = 64;
  // FIFO depth in words. This must be a power of two.
  localparam int c_larpix_fifo_depth = 512;
  // Base-2 logarithm of the FIFO depth.
  localparam int c_larpix_fifo_bits  = 9;

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : Synchronous simple-dual-port RAM, DEPTH x DATA_W. It has one
//               write port and one registered read port. The array itself
//               has no reset. The read register clears on reset so that the
//               popped-word output starts at zero.
//               A read and a write to the same address in the same cycle
//               return the old contents (read-before-write).
// Ports       : clk      - clock
//               reset_n  - asynchronous active-low reset (read register only)
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable; o_rdata updates on the next edge
//               i_raddr  - read address
//               o_rdata  - registered read data; holds when i_re=0
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
  parameter int DATA_W = 63,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/shared_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shared_event_fifo
// Description : Shared event FIFO between the event router and the packet
//               builder. It stores WIDTH-1 bit routed channel events in strict
//               first-in first-out order. It also provides registered
//               full/half/empty flags, an occupancy counter, a high-water
//               mark and a sticky overflow flag.
// Ports       : clk             - master clock, rising edge
//               reset_n         - asynchronous active-low reset
//               data_in         - event word to write
//               load_event      - write strobe, one cycle per word
//               read_n          - active-low pop request
//               clear_overflow  - clears the sticky overflow flag
//               data_out        - registered popped word
//               data_valid      - one-cycle strobe for a newly popped word
//               fifo_full       - count == FIFO_DEPTH
//               fifo_half       - count >= FIFO_DEPTH/2
//               fifo_empty      - count == 0
//               fifo_counter    - current occupancy
//               fifo_high_water - maximum occupancy since reset
//               fifo_overflow   - sticky, set when a write is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module shared_event_fifo
  import shared_event_fifo_pkg::*;
#(
  parameter int WIDTH      = c_larpix_width,
  parameter int FIFO_DEPTH = c_larpix_fifo_depth,
  parameter int FIFO_BITS  = c_larpix_fifo_bits
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-2:0]   data_in,
  input  logic               load_event,
  input  logic               read_n,
  input  logic               clear_overflow,
  output logic [WIDTH-2:0]   data_out,
  output logic               data_valid,
  output logic               fifo_full,
  output logic               fifo_half,
  output logic               fifo_empty,
  output logic [FIFO_BITS:0] fifo_counter,
  output logic [FIFO_BITS:0] fifo_high_water,
  output logic               fifo_overflow
);

  localparam logic [FIFO_BITS:0] c_depth = (FIFO_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_BITS:0] c_half  = (FIFO_BITS+1)'(FIFO_DEPTH/2);

  logic [FIFO_BITS-1:0] r_wr_ptr;
  logic [FIFO_BITS-1:0] r_rd_ptr;
  logic [FIFO_BITS:0]   r_count;
  logic [FIFO_BITS:0]   r_high_water;
  logic                 r_full;
  logic                 r_half;
  logic                 r_empty;
  logic                 r_valid;
  logic                 r_overflow;

  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic                 w_drop;
  logic [FIFO_BITS:0]   w_count_nxt;

  // A read is accepted only against words already counted. This gives a
  // word written this cycle no path to the read side until the next cycle.
  // When the FIFO is full, a write is still accepted if a read frees a slot
  // on the same edge.
  always_comb begin
    w_rd_acc    = !read_n && (r_count != '0);
    w_wr_acc    = load_event && ((r_count != c_depth) || w_rd_acc);
    w_drop      = load_event && !w_wr_acc;
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_high_water <= '0;
      r_full       <= 1'b0;
      r_half       <= 1'b0;
      r_empty      <= 1'b1;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      // Pointers are exactly FIFO_BITS wide. They wrap from DEPTH-1 to 0
      // through natural binary overflow.
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      // The flags are decoded from the next count. They are then registered
      // alongside the counter, so the flags and the counter always agree.
      r_full  <= (w_count_nxt == c_depth);
      r_half  <= (w_count_nxt >= c_half);
      r_empty <= (w_count_nxt == '0);
      r_valid <= w_rd_acc;
      // A dropped write has priority over clear_overflow.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
      // The high-water mark tracks the registered count. It never exceeds
      // FIFO_DEPTH, because the count cannot go past FIFO_DEPTH.
      if (r_count > r_high_water) begin
        r_high_water <= r_count;
      end
    end
  end

  fifo_ram #(
    .DATA_W (WIDTH-1),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (FIFO_BITS)
  ) u_fifo_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_out)
  );

  assign data_valid      = r_valid;
  assign fifo_full       = r_full;
  assign fifo_half       = r_half;
  assign fifo_empty      = r_empty;
  assign fifo_counter    = r_count;
  assign fifo_high_water = r_high_water;
  assign fifo_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_shared_event_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_shared_event_fifo
// Description : Self-checking bench for shared_event_fifo. It uses a queue
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_event_fifo;

  localparam int DEPTH = 512;

  logic        clk;
  logic        reset_n;
  logic [62:0] data_in;
  logic        load_event;
  logic        read_n;
  logic        clear_overflow;
  logic [62:0] data_out;
  logic        data_valid;
  logic        fifo_full;
  logic        fifo_half;
  logic        fifo_empty;
  logic [9:0]  fifo_counter;
  logic [9:0]  fifo_high_water;
  logic        fifo_overflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [62:0] m_q[$];
  logic [62:0] m_dout;
  logic        m_dv;
  logic        m_ovf;
  int          m_max;

  shared_event_fifo dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .data_in         (data_in),
    .load_event      (load_event),
    .read_n          (read_n),
    .clear_overflow  (clear_overflow),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .fifo_full       (fifo_full),
    .fifo_half       (fifo_half),
    .fifo_empty      (fifo_empty),
    .fifo_counter    (fifo_counter),
    .fifo_high_water (fifo_high_water),
    .fifo_overflow   (fifo_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_max  = 0;
  endtask

  // Drive one cycle of inputs, take the edge, then advance the model.
  task automatic cycle(input logic le, input logic rn, input logic clr, input logic [62:0] d);
    bit rd;
    bit wr;
    load_event     = le;
    read_n         = rn;
    clear_overflow = clr;
    data_in        = d;
    @(posedge clk);
    #1;
    rd = !rn && (m_q.size() > 0);
    wr = le && ((m_q.size() < DEPTH) || rd);
    if (rd) begin
      m_dout = m_q.pop_front();
      m_dv   = 1'b1;
    end else begin
      m_dv   = 1'b0;
    end
    if (wr) m_q.push_back(d);
    if (le && !wr) m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    if (m_q.size() > m_max) m_max = m_q.size();
    load_event     = 1'b0;
    read_n         = 1'b1;
    clear_overflow = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [62:0] rnd63();
    return 63'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    load_event = 1'b0; read_n = 1'b1; clear_overflow = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (data_out !== 63'h0 || data_valid !== 1'b0 || fifo_full !== 1'b0 || fifo_half !== 1'b0 ||
        fifo_empty !== 1'b1 || fifo_counter !== 10'd0 || fifo_high_water !== 10'd0 || fifo_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got dout=%h dv=%b full=%b half=%b empty=%b cnt=%0d hw=%0d ovf=%b, need 0 0 0 0 1 0 0 0",
               data_out, data_valid, fifo_full, fifo_half, fifo_empty, fifo_counter, fifo_high_water, fifo_overflow);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [62:0] exp_w;
    cycle(1'b1, 1'b1, 1'b0, 63'h1);
    cycle(1'b1, 1'b1, 1'b0, 63'h2);
    cycle(1'b1, 1'b1, 1'b0, 63'h3);
    total++;
    if (fifo_counter !== 10'd3 || fifo_empty !== 1'b0) begin
      bad++;
      $display("FAIL basic_count: got cnt=%0d empty=%b, need 3 0", fifo_counter, fifo_empty);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      exp_w = 63'(i + 1);
      total++;
      if (data_valid !== 1'b1 || data_out !== exp_w) begin
        bad++;
        $display("FAIL basic_pop%0d: got dv=%b dout=%h, need 1 %h", i, data_valid, data_out, exp_w);
      end
    end
    total++;
    if (fifo_empty !== 1'b1 || fifo_counter !== 10'd0) begin
      bad++;
      $display("FAIL basic_empty: got empty=%b cnt=%0d, need 1 0", fifo_empty, fifo_counter);
    end
    cycle(1'b0, 1'b0, 1'b0, '0);  // read while empty is ignored
    total++;
    if (data_valid !== 1'b0 || data_out !== 63'h3 || fifo_counter !== 10'd0) begin
      bad++;
      $display("FAIL basic_hold: got dv=%b dout=%h cnt=%0d, need 0 3 0", data_valid, data_out, fifo_counter);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, 1'b0, rnd63());
      if (i == 254 || i == 255) begin
        total++;
        if (fifo_half !== (i == 255)) begin
          bad++;
          $display("FAIL fill_half at count %0d: got half=%b, need %b", i + 1, fifo_half, (i == 255));
        end
      end
      if (i == 510 || i == 511) begin
        total++;
        if (fifo_full !== (i == 511) || fifo_counter !== 10'(i + 1)) begin
          bad++;
          $display("FAIL fill_full at count %0d: got full=%b cnt=%0d, need %b %0d",
                   i + 1, fifo_full, fifo_counter, (i == 511), i + 1);
        end
      end
    end
    cycle(1'b1, 1'b1, 1'b0, rnd63());
    total++;
    if (fifo_overflow !== 1'b1 || fifo_counter !== 10'd512 || fifo_full !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: got ovf=%b cnt=%0d full=%b, need 1 512 1", fifo_overflow, fifo_counter, fifo_full);
    end
    cycle(1'b1, 1'b1, 1'b1, rnd63());
    total++;
    if (fifo_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set_priority: got ovf=%b, need 1", fifo_overflow);
    end
    cycle(1'b0, 1'b1, 1'b1, '0);
    total++;
    if (fifo_overflow !== m_ovf || fifo_overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear: got ovf=%b, need 0", fifo_overflow);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    total++;
    if (fifo_high_water !== 10'(m_max) || fifo_high_water !== 10'd512) begin
      bad++;
      $display("FAIL fill_high_water: got hw=%0d, need 512", fifo_high_water);
    end
  endtask

  task automatic test_full_simul();
    cycle(1'b1, 1'b0, 1'b0, rnd63());
    total++;
    if (data_valid !== 1'b1 || data_out !== m_dout || fifo_counter !== 10'd512 ||
        fifo_overflow !== 1'b0 || fifo_full !== 1'b1) begin
      bad++;
      $display("FAIL full_simul: got dv=%b dout=%h cnt=%0d ovf=%b full=%b, need 1 %h 512 0 1",
               data_valid, data_out, fifo_counter, fifo_overflow, fifo_full, m_dout);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      total++;
      if (data_valid !== 1'b1 || data_out !== m_dout) begin
        bad++;
        $display("FAIL drain_%0d: got dv=%b dout=%h, need 1 %h", i, data_valid, data_out, m_dout);
      end
    end
    total++;
    if (fifo_empty !== 1'b1 || fifo_counter !== 10'd0 || fifo_half !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: got empty=%b cnt=%0d half=%b, need 1 0 0", fifo_empty, fifo_counter, fifo_half);
    end
  endtask

  task automatic test_empty_simul();
    logic [62:0] w;
    w = rnd63();
    cycle(1'b1, 1'b0, 1'b0, w);
    total++;
    if (data_valid !== 1'b0 || fifo_counter !== 10'd1 || fifo_empty !== 1'b0) begin
      bad++;
      $display("FAIL empty_simul: got dv=%b cnt=%0d empty=%b, need 0 1 0", data_valid, fifo_counter, fifo_empty);
    end
    cycle(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (data_valid !== 1'b1 || data_out !== w) begin
      bad++;
      $display("FAIL empty_simul_read: got dv=%b dout=%h, need 1 %h", data_valid, data_out, w);
    end
  endtask

  task automatic test_random();
    int sz;
    int wp;
    int rp;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      wp = (c < 1100) ? 85 : 20;
      rp = (c < 1100) ? 25 : 80;
      cycle(($urandom_range(99) < wp), !($urandom_range(99) < rp), ($urandom_range(99) < 5), rnd63());
      sz = m_q.size();
      total++;
      if (data_valid !== m_dv || data_out !== m_dout) begin
        bad++;
        $display("FAIL rand_data c=%0d: got dv=%b dout=%h, need %b %h", c, data_valid, data_out, m_dv, m_dout);
      end
      total++;
      if (fifo_counter !== sz[9:0]) begin
        bad++;
        $display("FAIL rand_count c=%0d: got %0d, need %0d", c, fifo_counter, sz);
      end
      total++;
      if (fifo_full !== (sz == DEPTH) || fifo_half !== (sz >= DEPTH / 2) || fifo_empty !== (sz == 0)) begin
        bad++;
        $display("FAIL rand_flags c=%0d: got full=%b half=%b empty=%b for count %0d",
                 c, fifo_full, fifo_half, fifo_empty, sz);
      end
      total++;
      if (fifo_overflow !== m_ovf) begin
        bad++;
        $display("FAIL rand_overflow c=%0d: got %b, need %b", c, fifo_overflow, m_ovf);
      end
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    total++;
    if (fifo_high_water !== 10'(m_max)) begin
      bad++;
      $display("FAIL rand_high_water: got %0d, need %0d", fifo_high_water, m_max);
    end
  endtask

  task automatic test_reset_mid();
    logic [62:0] w;
    do_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'b0, rnd63());
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, rnd63());
    total++;
    if (fifo_counter !== 10'd100) begin
      bad++;
      $display("FAIL mid_pre_count: got %0d, need 100", fifo_counter);
    end
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (data_out !== 63'h0 || data_valid !== 1'b0 || fifo_full !== 1'b0 || fifo_half !== 1'b0 ||
        fifo_empty !== 1'b1 || fifo_counter !== 10'd0 || fifo_high_water !== 10'd0 || fifo_overflow !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: got dout=%h dv=%b full=%b half=%b empty=%b cnt=%0d hw=%0d ovf=%b, need 0 0 0 0 1 0 0 0",
               data_out, data_valid, fifo_full, fifo_half, fifo_empty, fifo_counter, fifo_high_water, fifo_overflow);
    end
    #2;
    reset_n = 1'b1;
    model_reset();
    w = rnd63();
    cycle(1'b1, 1'b1, 1'b0, w);
    cycle(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (data_valid !== 1'b1 || data_out !== w || fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_next_word: got dv=%b dout=%h empty=%b, need 1 %h 1", data_valid, data_out, fifo_empty, w);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_simul();
    test_empty_simul();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shared_event_fifo.md
SHARED_EVENT_FIFO -- requirements
Module: shared_event_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64, packet width; the stored word is WIDTH-1 = 63 bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 512, number of words, power of two.
REQ-003 SHALL have parameter FIFO_BITS, default 9, equal to log2(FIFO_DEPTH).
REQ-004 SHALL have port clk, input, 1, master clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port data_in, input, WIDTH-1, routed channel event from the event router.
REQ-007 SHALL have port load_event, input, 1, high for one cycle per word to write.
REQ-008 SHALL have port read_n, input, 1, low to pop one word (downstream packet builder).
REQ-009 SHALL have port clear_overflow, input, 1, high for one cycle to clear the sticky overflow flag.
REQ-010 SHALL have port data_out, output, WIDTH-1, registered popped word.
REQ-011 SHALL have port data_valid, output, 1, high for one cycle when data_out holds a newly popped word.
REQ-012 SHALL have port fifo_full, output, 1, count == FIFO_DEPTH; consumed by every channel_ctrl.
REQ-013 SHALL have port fifo_half, output, 1, count >= FIFO_DEPTH/2; consumed by every channel_ctrl.
REQ-014 SHALL have port fifo_empty, output, 1, count == 0.
REQ-015 SHALL have port fifo_counter, output, FIFO_BITS+1, current occupancy for FIFO diagnostics.
REQ-016 SHALL have port fifo_high_water, output, FIFO_BITS+1, maximum occupancy since reset.
REQ-017 SHALL have port fifo_overflow, output, 1, sticky; set when a write is dropped.

Function
REQ-018 A write SHALL be accepted when load_event=1 and (count<FIFO_DEPTH or a read is accepted in the same cycle).
REQ-019 A read SHALL be accepted when read_n=0 and count>0; a read while empty SHALL be ignored, including when a write is simultaneous.
REQ-020 An accepted read SHALL drive the head word onto data_out and assert data_valid on the next clk edge (1-cycle latency); otherwise data_valid=0 and data_out SHALL hold its value.
REQ-021 Count SHALL be +1 on write only, -1 on read only, and unchanged on simultaneous accepted read and write.
REQ-022 Read and write pointers SHALL be FIFO_BITS wide and wrap from FIFO_DEPTH-1 to 0 with no gap.
REQ-023 A write at count==FIFO_DEPTH with no accepted read SHALL be dropped, leave memory and pointers unchanged, and set fifo_overflow on the next edge.
REQ-024 clear_overflow SHALL clear fifo_overflow; when clear_overflow and a dropped write occur together, set SHALL take priority.
REQ-025 fifo_full, fifo_half and fifo_empty SHALL be registered and consistent with fifo_counter in the same cycle (no combinational path from inputs).
REQ-026 fifo_high_water SHALL update to count whenever the registered count exceeds it; it SHALL saturate at FIFO_DEPTH.
REQ-027 Data order SHALL be strict first-in first-out; a word written at cycle N SHALL NOT be readable before cycle N+1.

Reset
REQ-028 While reset_n=0: pointers=0, count=0, data_out=0, data_valid=0, fifo_full=0, fifo_half=0, fifo_empty=1, fifo_counter=0, fifo_high_water=0, fifo_overflow=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored words immediately; memory contents need not be cleared.

Structure
REQ-030 WIDTH, FIFO_DEPTH and FIFO_BITS defaults SHALL come from the shared larpix constants package.
REQ-031 Storage SHALL be one sub-module, fifo_ram: a synchronous simple-dual-port RAM with 1 write port and 1 registered read port, FIFO_DEPTH x (WIDTH-1), with no reset on the array.

Verification
REQ-032 After reset, write 3 words 0x1, 0x2, 0x3, then hold read_n=0 for 3 cycles -> data_out = 0x1, 0x2, 0x3 on consecutive cycles with data_valid=1; fifo_empty=1 afterwards.
REQ-033 Write 512 words -> fifo_half=1 at count 256, fifo_full=1 at 512; a 513th write -> dropped, fifo_overflow=1, count stays 512; clear_overflow -> fifo_overflow=0.
REQ-034 At count=512, assert load_event and read_n=0 together -> both accepted, count stays 512, no overflow, the oldest word is popped.
REQ-035 At empty, assert load_event and read_n=0 together -> no data_valid, count becomes 1; the next read returns the written word.
REQ-036 Run 2000 cycles of random writes and reads against a queue model -> data matches, pointers wrap repeatedly, and fifo_high_water equals the model's maximum count.
REQ-037 Pulse reset_n low at count=100 -> all outputs take their reset values asynchronously; the next word written is the next word read.
